// File: rtl/fetch_pkg.sv
// Shared opcodes, data width and FSM state encoding for the fetch sequencer.
package fetch_pkg;
  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALTED
  } state_t;
endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-pc selection: jump, taken beq or sequential, all modulo 2^ADDR_W.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [INSTR_W-1:0] instruction,
  input  logic [ADDR_W-1:0]  instr_pc,
  input  logic               zero_flag,
  output logic [ADDR_W-1:0]  next_pc
);
  logic [5:0]  opcode;
  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic        unused_bits;

  assign opcode = instruction[31:26];
  // Arithmetic is done 32 bits wide and truncated, which gives the silent wrap.
  assign seq_pc = 32'(instr_pc) + 32'd1;
  assign br_pc  = seq_pc + {{16{instruction[15]}}, instruction[15:0]};

  always_comb begin
    next_pc = seq_pc[ADDR_W-1:0];
    if (opcode == OP_J) begin
      next_pc = instruction[ADDR_W-1:0];
    end else if ((opcode == OP_BEQ) && zero_flag) begin
      next_pc = br_pc[ADDR_W-1:0];
    end
  end

  assign unused_bits = ^{instruction[25:16], seq_pc[31:ADDR_W], br_pc[31:ADDR_W]};
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetch from imem, offer downstream, pick next pc at handshake.
// Optional FETCH_PERF_CNT_EN adds a 32-bit handshake counter output fetch_count.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               zero_flag,
  input  logic               halt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count
`endif
);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  state_t               state_q;
  logic [ADDR_W-1:0]    pc_q;
  logic [ADDR_W-1:0]    instr_pc_q;
  logic [ADDR_W-1:0]    next_pc_d;
  logic [INSTR_W-1:0]   instr_q;
  logic                 req_q;
  logic                 valid_q;
  logic                 handshake;

  // instr_valid is high for the whole of ISSUE, so the handshake needs only ready.
  assign handshake = (state_q == ISSUE) && instr_ready;

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .instruction(instr_q),
    .instr_pc   (instr_pc_q),
    .zero_flag  (zero_flag),
    .next_pc    (next_pc_d)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RST_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (halt) begin
            state_q <= HALTED;
          end else begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            req_q      <= 1'b0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (handshake) begin
            pc_q    <= next_pc_d;
            valid_q <= 1'b0;
            if (halt) begin
              state_q <= HALTED;
            end else begin
              state_q <= FETCH;
              req_q   <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (!halt) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_q <= '0;
    end else if (handshake) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: memory responder pushes expected issues, monitor checks
// them and tracks the architectural pc with a reference model of the branch/jump rules.
module tb_fetch_sequencer;
  localparam int AW   = 8;
  localparam int MASK = (1 << AW) - 1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [AW-1:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instruction;
  logic [AW-1:0] instr_pc;
  logic        zero_flag = 1'b0;
  logic        halt = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  always #5 clock = ~clock;

  fetch_sequencer #(.ADDR_W(AW), .RESET_PC(0)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instruction(instruction),
    .instr_pc   (instr_pc),
    .zero_flag  (zero_flag),
    .halt       (halt)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   word;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem [256];
  exp_t        exp_q[$];
  int          acked_addr[$];
  int          ref_pc = 0;
  bit          ref_halted = 0;
  int          hs_cnt = 0;
  int          ack_cnt = 0;
  bit          beq_seen = 0;
  bit          resp_en = 0;
  bit          rand_mode = 0;
  int          dly = 2;
  int          wait_cnt = 0;
  int          exp_seq[15] = '{0, 1, 2, 3, 4, 5, 64, 65, 10, 8, 9, 10, 11, 255, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pc rule: jump target, pc+1+imm on a taken beq, else pc+1, all mod 2^AW.
  function automatic int ref_next(input logic [31:0] w, input int pc, input bit z);
    int op;
    int imm;
    op = int'(w[31:26]);
    if (op == 2) return int'(w) & MASK;
    if (op == 4 && z) begin
      imm = int'(w[15:0]);
      if (imm >= 32768) imm -= 65536;
      return (pc + 1 + imm) & MASK;
    end
    return (pc + 1) & MASK;
  endfunction

  // Instruction memory responder: acks each request after dly cycles and logs the expected issue.
  initial begin
    forever begin
      @(negedge clock);
      imem_ack = 1'b0;
      if (!reset_n || !imem_req || !resp_en) begin
        wait_cnt = 0;
      end else if (wait_cnt >= dly) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        exp_q.push_back('{pc: imem_addr, word: mem[imem_addr]});
        wait_cnt = 0;
        dly = rand_mode ? int'($urandom_range(0, 3)) : 2;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Monitor: samples just before each rising edge, when every input and output is settled.
  initial begin
    exp_t        cur;
    bit          expect_valid;
    bit          prev_valid;
    bit          prev_stall;
    logic [31:0] prev_instr;
    logic [AW-1:0] prev_ipc;
    cur = '0;
    expect_valid = 0;
    prev_valid = 0;
    prev_stall = 0;
    prev_instr = '0;
    prev_ipc = '0;
    forever begin
      @(negedge clock);
      #4;
      if (!reset_n) begin
        ref_pc = 0;
        ref_halted = 0;
        exp_q.delete();
        expect_valid = 0;
        prev_valid = 0;
        prev_stall = 0;
        continue;
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(instr_valid), 64'd1);
        chk("stall_instr", 64'(instruction), 64'(prev_instr));
        chk("stall_pc", 64'(instr_pc), 64'(prev_ipc));
        chk("stall_req", 64'(imem_req), 64'd0);
      end
      if (expect_valid || (instr_valid && !prev_valid)) begin
        chk("ack_to_valid", 64'(instr_valid), 64'(expect_valid));
        if (instr_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            chk("issue_without_fetch", 64'(exp_q.size()), 64'd1);
          end else begin
            cur = exp_q.pop_front();
            chk("issue_instr", 64'(instruction), 64'(cur.word));
            chk("issue_pc", 64'(instr_pc), 64'(cur.pc));
          end
        end
      end
      if (ref_halted) begin
        chk("halted_req", 64'(imem_req), 64'd0);
        chk("halted_valid", 64'(instr_valid), 64'd0);
      end
      expect_valid = 0;
      if (imem_req && imem_ack) begin
        chk("fetch_addr", 64'(imem_addr), 64'(ref_pc));
        acked_addr.push_back(int'(imem_addr));
        ack_cnt++;
        expect_valid = 1;
      end
      if (instr_valid && instr_ready) begin
        hs_cnt++;
        if (int'(cur.pc) == 10 && cur.word == 32'h1000FFFD && zero_flag) beq_seen = 1;
        ref_pc = ref_next(cur.word, int'(cur.pc), zero_flag);
        ref_halted = halt;
      end else if (ref_halted && !halt) begin
        ref_halted = 0;
      end
      prev_stall = instr_valid && !instr_ready;
      prev_instr = instruction;
      prev_ipc = instr_pc;
      prev_valid = instr_valid;
    end
  end

  initial begin
    int h0;
    int a0;
    int saved_pc;
    for (int i = 0; i < 256; i++) mem[i] = 32'h20000000;
    mem[5]    = 32'h08000040;
    mem[8'h41] = 32'h0800000A;
    mem[10]   = 32'h1000FFFD;
    mem[11]   = 32'h080000FF;

    // Reset values
    repeat (2) @(negedge clock);
    #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instruction), 64'd0);
    chk("rst_ipc", 64'(instr_pc), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    resp_en = 1'b1;

    // Directed walk: sequential, jump, taken/untaken beq, wrap past 255
    for (int i = 0; i < 400 && ack_cnt < 15; i++) begin
      @(negedge clock);
      zero_flag = instr_valid && (int'(instr_pc) == 10) && !beq_seen;
    end
    zero_flag = 1'b0;
    chk("seq_timeout", 64'(ack_cnt >= 15), 64'd1);
    for (int k = 0; k < 15 && k < acked_addr.size(); k++)
      chk($sformatf("seq_addr[%0d]", k), 64'(acked_addr[k]), 64'(exp_seq[k]));

    // Downstream stall for 4 cycles, then exactly one handshake
    for (int i = 0; i < 50 && !instr_valid; i++) @(negedge clock);
    chk("stall_wait_timeout", 64'(instr_valid), 64'd1);
    instr_ready = 1'b0;
    h0 = hs_cnt;
    repeat (4) @(negedge clock);
    chk("stall_no_hs", 64'(hs_cnt), 64'(h0));
    instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
    @(negedge clock);
    chk("stall_one_hs", 64'(hs_cnt), 64'(h0 + 1));
    instr_ready = 1'b1;

    // Halt raised during FETCH: ack still consumed, halt at handshake, resume at next pc
    for (int i = 0; i < 50 && !imem_req; i++) @(negedge clock);
    chk("halt_wait_timeout", 64'(imem_req), 64'd1);
    halt = 1'b1;
    h0 = hs_cnt;
    for (int i = 0; i < 50 && hs_cnt == h0; i++) @(negedge clock);
    chk("halt_hs_timeout", 64'(hs_cnt), 64'(h0 + 1));
    saved_pc = ref_pc;
    a0 = ack_cnt;
    repeat (4) @(negedge clock);
    chk("halt_no_req", 64'(imem_req), 64'd0);
    chk("halt_no_valid", 64'(instr_valid), 64'd0);
    chk("halt_no_ack", 64'(ack_cnt), 64'(a0));
    halt = 1'b0;
    for (int i = 0; i < 50 && !imem_req; i++) @(negedge clock);
    chk("resume_req", 64'(imem_req), 64'd1);
    chk("resume_addr", 64'(imem_addr), 64'(saved_pc));
`ifdef FETCH_PERF_CNT_EN
    for (int i = 0; i < 50 && !instr_valid; i++) @(negedge clock);
    chk("perf_count", 64'(fetch_count), 64'(hs_cnt));
`endif

    // Reset while a fetch is outstanding, then a stray ack
    for (int i = 0; i < 50 && !imem_req; i++) @(negedge clock);
    chk("rst2_wait_timeout", 64'(imem_req), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst2_req", 64'(imem_req), 64'd0);
    chk("rst2_addr", 64'(imem_addr), 64'd0);
    chk("rst2_valid", 64'(instr_valid), 64'd0);
    chk("rst2_instr", 64'(instruction), 64'd0);
    chk("rst2_ipc", 64'(instr_pc), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst2_count", 64'(fetch_count), 64'd0);
`endif
    @(negedge clock);
    resp_en = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clock);
    #1;
    chk("stray_req", 64'(imem_req), 64'd1);
    chk("stray_addr", 64'(imem_addr), 64'd0);
    chk("stray_valid", 64'(instr_valid), 64'd0);
    resp_en = 1'b1;

    // Randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 3))
        0: mem[i] = 32'h08000000 | ($urandom & 32'h03FFFFFF);
        1: mem[i] = 32'h10000000 | ($urandom & 32'h03FFFFFF);
        default: mem[i] = $urandom & 32'hF3FFFFFF;
      endcase
    end
    a0 = ack_cnt;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      instr_ready = ($urandom_range(0, 3) != 0);
      zero_flag = 1'($urandom_range(0, 1));
      halt = ($urandom_range(0, 7) == 0);
    end
    halt = 1'b0;
    instr_ready = 1'b1;
    repeat (20) @(negedge clock);
    chk("random_progress", 64'(ack_cnt - a0 > 200), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
